// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : debounce_edge
// Purpose  : Turns a raw, asynchronous, bouncing input (push-button or
//            switch) into a clean registered level plus single-cycle rise and
//            fall pulses. The input passes through a 2-FF synchronizer, a
//            debounce counter and a 4-state FSM.
// Ports    : Clk        - system clock, rising edge
//            Rst        - asynchronous reset, active-low
//            Btn_in     - raw asynchronous input, may bounce
//            Db_out     - debounced, registered level
//            Rise_pulse - 1-cycle pulse in the first cycle Db_out is 1
//            Fall_pulse - 1-cycle pulse in the first cycle Db_out is 0
//            Busy       - 1 while a new level is being qualified
//            Long_pulse - 1-cycle long-press pulse (0 unless enabled)
// Options  : define DEB_LONGPRESS_EN to build the long-press detector
// Revision : 1.0 - initial release
// ============================================================================
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int LONG_CYCLES     = 40000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Btn_in,
  output logic Db_out,
  output logic Rise_pulse,
  output logic Fall_pulse,
  output logic Busy,
  output logic Long_pulse
);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic             r_sync_q1;
  logic             r_sync_q2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_rise_nx;
  logic             w_fall_nx;
  logic             w_db_nx;
  logic             w_busy_nx;

  // Two-stage synchronizer; nothing downstream looks at Btn_in directly.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync_q1 <= 1'b0;
      r_sync_q2 <= 1'b0;
    end else begin
      r_sync_q1 <= Btn_in;
      r_sync_q2 <= r_sync_q1;
    end
  end

  // Next-state logic. The counter is zero in both STABLE states and on
  // every exit from a WAIT state, so it can never run past C_CNT_LAST.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_rise_nx  = 1'b0;
    w_fall_nx  = 1'b0;
    case (r_state)
      ST_STABLE_LO: begin
        if (r_sync_q2) begin
          w_state_nx = ST_WAIT_HI;
          w_cnt_nx   = C_CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!r_sync_q2) begin
          w_state_nx = ST_STABLE_LO;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nx = ST_STABLE_HI;
          w_rise_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!r_sync_q2) begin
          w_state_nx = ST_WAIT_LO;
          w_cnt_nx   = C_CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (r_sync_q2) begin
          w_state_nx = ST_STABLE_HI;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nx = ST_STABLE_LO;
          w_fall_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_STABLE_LO;
      end
    endcase
    // The debounced level is 1 exactly while the accepted level is high,
    // which includes the time spent qualifying a release.
    w_db_nx   = (w_state_nx == ST_STABLE_HI) || (w_state_nx == ST_WAIT_LO);
    w_busy_nx = (w_state_nx == ST_WAIT_HI) || (w_state_nx == ST_WAIT_LO);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= ST_STABLE_LO;
      r_cnt      <= '0;
      Db_out     <= 1'b0;
      Rise_pulse <= 1'b0;
      Fall_pulse <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      Db_out     <= w_db_nx;
      Rise_pulse <= w_rise_nx;
      Fall_pulse <= w_fall_nx;
      Busy       <= w_busy_nx;
    end
  end

`ifdef DEB_LONGPRESS_EN
  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_lcnt;
  logic             r_ldone;

  // Counts cycles spent holding high after the rise commit. r_ldone freezes
  // the counter once the pulse has fired so each press yields one pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_lcnt     <= '0;
      r_ldone    <= 1'b0;
      Long_pulse <= 1'b0;
    end else begin
      Long_pulse <= 1'b0;
      if ((r_state == ST_STABLE_HI) && r_sync_q2) begin
        if (!r_ldone) begin
          if (r_lcnt == C_LONG_LAST) begin
            Long_pulse <= 1'b1;
            r_ldone    <= 1'b1;
          end else begin
            r_lcnt <= r_lcnt + C_CNT_ONE;
          end
        end
      end else begin
        r_lcnt  <= '0;
        r_ldone <= 1'b0;
      end
    end
  end
`else
  // Long-press detector not built; LONG_CYCLES has no effect here.
  assign Long_pulse = 1'b0 & (LONG_CYCLES != 0);
`endif

endmodule
`default_nettype wire
